psw_ctl: RTL and testbench

PSW_CTL -- requirements
Module: psw_ctl

---
 rtl/pdp11_psw_pkg.sv | 31 +++
 rtl/psw_trace_fsm.sv | 60 ++++++
 rtl/psw_ctl.sv | 106 ++++++++++
 tb/tb_psw_ctl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp11_psw_pkg.sv
// Shared PSW definitions: field positions, mode and address encodings,
// trace-FSM state codes and a helper that clears the reserved bits.
package pdp11_psw_pkg;

    localparam int PSW_CM_HI   = 15;
    localparam int PSW_CM_LO   = 14;
    localparam int PSW_PM_HI   = 13;
    localparam int PSW_PM_LO   = 12;
    localparam int PSW_PRI_HI  = 7;
    localparam int PSW_PRI_LO  = 5;
    localparam int PSW_T       = 4;
    localparam int PSW_CC_HI   = 3;
    localparam int PSW_CC_LO   = 0;

    localparam logic [1:0] MODE_KERNEL = 2'b00;
    localparam logic [1:0] MODE_SUPER  = 2'b01;
    localparam logic [1:0] MODE_USER   = 2'b11;

    localparam logic [12:0] PSW_ADDR_LO = 13'o17776;
    localparam logic [12:0] PSW_ADDR_HI = 13'o17777;

    localparam logic [1:0] T_IDLE    = 2'd0;
    localparam logic [1:0] T_ARMED   = 2'd1;
    localparam logic [1:0] T_INHIBIT = 2'd2;

    // Bits [11:8] of the PSW do not exist and always read as zero.
    function automatic logic [15:0] pswClean(input logic [15:0] p);
        return {p[15:12], 4'b0000, p[7:0]};
    endfunction

endpackage

// File: rtl/psw_trace_fsm.sv
// Trace-trap sequencer: arms at instruction fetch when T is set and raises a
// one-cycle trace request after that instruction completes.
module psw_trace_fsm
    import pdp11_psw_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_tBit,
    input  logic i_instrStart,
    input  logic i_instrDone,
    input  logic i_trapLd,
    input  logic i_rttLd,
    output logic o_traceReq
);

    logic [1:0] r_state;
    logic       r_traceReq;
    logic [1:0] w_base;
    logic [1:0] w_nextState;
    logic       w_fire;

    // Next state: trap and RTT override instruction events; completion of the
    // current instruction is resolved before the next fetch is considered.
    always_comb begin
        w_base      = ((r_state == T_ARMED) || (r_state == T_INHIBIT)) ? r_state : T_IDLE;
        w_nextState = w_base;
        w_fire      = 1'b0;
        if (i_trapLd) begin
            w_nextState = T_IDLE;
        end else if (i_rttLd) begin
            w_nextState = T_INHIBIT;
        end else begin
            if (i_instrDone && (w_base == T_ARMED)) begin
                w_fire      = 1'b1;
                w_nextState = T_IDLE;
            end
            if (i_instrStart) begin
                if (w_nextState == T_INHIBIT) begin
                    w_nextState = T_IDLE;
                end else if ((w_nextState == T_IDLE) && i_tBit) begin
                    w_nextState = T_ARMED;
                end
            end
        end
    end

    // State and registered trace request.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= T_IDLE;
            r_traceReq <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_traceReq <= w_fire;
        end
    end

    assign o_traceReq = r_traceReq;

endmodule

// File: rtl/psw_ctl.sv
// PDP-11 processor status word: prioritised update mux for trap, RTI/RTT,
// I/O-page writes, SPL and condition codes, plus the trace-trap sequencer.
module psw_ctl
    import pdp11_psw_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [12:0] iopage_addr,
    input  logic [15:0] data_in,
    input  logic        iopage_wr,
    input  logic        iopage_byte_op,
    input  logic        cc_wr,
    input  logic [3:0]  cc_in,
    input  logic        spl_wr,
    input  logic [2:0]  spl_in,
    input  logic        trap_ld,
    input  logic [15:0] trap_psw,
    input  logic        rti_ld,
    input  logic        rtt,
    input  logic [15:0] stk_psw,
    input  logic        instr_start,
    input  logic        instr_done,
    output logic [15:0] psw,
    output logic        psw_sel,
    output logic        trace_req
);

    logic [15:0] r_psw;
    logic        r_ccSup;
    logic [15:0] w_pswNext;
    logic        w_ioWr;
    logic        w_kernel;
    logic        w_loByte;
    logic        w_hiByte;
    logic        w_unusedBits;

    assign psw_sel  = (iopage_addr == PSW_ADDR_LO) || (iopage_addr == PSW_ADDR_HI);
    assign w_ioWr   = iopage_wr && psw_sel;
    assign w_kernel = (r_psw[PSW_CM_HI:PSW_CM_LO] == MODE_KERNEL);
    assign w_loByte = !iopage_byte_op || (iopage_addr == PSW_ADDR_LO);
    assign w_hiByte = !iopage_byte_op || (iopage_addr == PSW_ADDR_HI);

    // Trap vector bits 13:8 and the reserved/T bits of I/O data never reach the PSW.
    assign w_unusedBits = ^{trap_psw[13:8], data_in[11:8], data_in[4]};

    // Single prioritised update per cycle; a lower-priority request is dropped
    // whenever a higher one is present, even if the higher one changes nothing.
    always_comb begin
        w_pswNext = r_psw;
        if (trap_ld) begin
            w_pswNext = {trap_psw[PSW_CM_HI:PSW_CM_LO], r_psw[PSW_CM_HI:PSW_CM_LO],
                         4'b0000, trap_psw[7:0]};
        end else if (rti_ld) begin
            if (w_kernel) begin
                w_pswNext = pswClean(stk_psw);
            end else begin
                w_pswNext = {r_psw[15:12] | stk_psw[15:12], 4'b0000,
                             r_psw[PSW_PRI_HI:PSW_PRI_LO], stk_psw[4:0]};
            end
        end else if (w_ioWr) begin
            if (w_hiByte) begin
                w_pswNext[15:12] = data_in[15:12];
            end
            if (w_loByte) begin
                w_pswNext[PSW_PRI_HI:PSW_PRI_LO] = data_in[PSW_PRI_HI:PSW_PRI_LO];
                w_pswNext[PSW_CC_HI:PSW_CC_LO]   = data_in[PSW_CC_HI:PSW_CC_LO];
            end
        end else if (spl_wr) begin
            if (w_kernel) begin
                w_pswNext[PSW_PRI_HI:PSW_PRI_LO] = spl_in;
            end
        end else if (cc_wr && !r_ccSup) begin
            w_pswNext[PSW_CC_HI:PSW_CC_LO] = cc_in;
        end
    end

    // PSW register and the flag that blocks ALU cc updates after a PSW write
    // until the next instruction fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_psw   <= 16'o000000;
            r_ccSup <= 1'b0;
        end else begin
            r_psw <= pswClean(w_pswNext);
            if (w_ioWr) begin
                r_ccSup <= 1'b1;
            end else if (instr_start) begin
                r_ccSup <= 1'b0;
            end
        end
    end

    psw_trace_fsm uTraceFsm (
        .clk          (clk),
        .reset        (reset),
        .i_tBit       (r_psw[PSW_T]),
        .i_instrStart (instr_start),
        .i_instrDone  (instr_done),
        .i_trapLd     (trap_ld),
        .i_rttLd      (rti_ld && rtt),
        .o_traceReq   (trace_req)
    );

    assign psw = r_psw;

endmodule

// File: tb/tb_psw_ctl.sv
// Self-checking bench for psw_ctl: directed vector table followed by random
// stimulus compared against a field-level reference model.
module tb_psw_ctl;

    typedef struct {
        logic        rst;
        logic [12:0] addr;
        logic [15:0] din;
        logic        wr;
        logic        byteOp;
        logic        ccWr;
        logic [3:0]  ccIn;
        logic        splWr;
        logic [2:0]  splIn;
        logic        trapLd;
        logic [15:0] trapPsw;
        logic        rtiLd;
        logic        rttIn;
        logic [15:0] stkPsw;
        logic        iStart;
        logic        iDone;
    } stim_t;

    typedef struct {
        string       name;
        stim_t       s;
        logic [15:0] expPsw;
        logic        expTr;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [12:0] iopage_addr;
    logic [15:0] data_in;
    logic        iopage_wr;
    logic        iopage_byte_op;
    logic        cc_wr;
    logic [3:0]  cc_in;
    logic        spl_wr;
    logic [2:0]  spl_in;
    logic        trap_ld;
    logic [15:0] trap_psw;
    logic        rti_ld;
    logic        rtt;
    logic [15:0] stk_psw;
    logic        instr_start;
    logic        instr_done;
    logic [15:0] psw;
    logic        psw_sel;
    logic        trace_req;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    // Reference model state, kept as separate PSW fields.
    int mCur, mPrev, mPrio, mT, mNzvc;
    bit mCcSup, mArmed, mInhibit, mTr;

    psw_ctl dut (
        .clk            (clk),
        .reset          (reset),
        .iopage_addr    (iopage_addr),
        .data_in        (data_in),
        .iopage_wr      (iopage_wr),
        .iopage_byte_op (iopage_byte_op),
        .cc_wr          (cc_wr),
        .cc_in          (cc_in),
        .spl_wr         (spl_wr),
        .spl_in         (spl_in),
        .trap_ld        (trap_ld),
        .trap_psw       (trap_psw),
        .rti_ld         (rti_ld),
        .rtt            (rtt),
        .stk_psw        (stk_psw),
        .instr_start    (instr_start),
        .instr_done     (instr_done),
        .psw            (psw),
        .psw_sel        (psw_sel),
        .trace_req      (trace_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idleS();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t rstS();
        stim_t s = idleS();
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic stim_t ioS(logic [12:0] a, logic [15:0] d, logic b);
        stim_t s = idleS();
        s.wr = 1'b1; s.addr = a; s.din = d; s.byteOp = b;
        return s;
    endfunction

    function automatic stim_t trapS(logic [15:0] p);
        stim_t s = idleS();
        s.trapLd = 1'b1; s.trapPsw = p;
        return s;
    endfunction

    function automatic stim_t rtiS(logic [15:0] p, logic t);
        stim_t s = idleS();
        s.rtiLd = 1'b1; s.stkPsw = p; s.rttIn = t;
        return s;
    endfunction

    function automatic stim_t ccS(logic [3:0] c);
        stim_t s = idleS();
        s.ccWr = 1'b1; s.ccIn = c;
        return s;
    endfunction

    function automatic stim_t splS(logic [2:0] v);
        stim_t s = idleS();
        s.splWr = 1'b1; s.splIn = v;
        return s;
    endfunction

    function automatic stim_t instrS(logic st, logic dn);
        stim_t s = idleS();
        s.iStart = st; s.iDone = dn;
        return s;
    endfunction

    function automatic void addVec(string n, stim_t s, logic [15:0] p, logic t);
        vec_t v;
        v.name = n; v.s = s; v.expPsw = p; v.expTr = t;
        vecs.push_back(v);
    endfunction

    task automatic applyStimulus(input stim_t s);
        reset          = s.rst;
        iopage_addr    = s.addr;
        data_in        = s.din;
        iopage_wr      = s.wr;
        iopage_byte_op = s.byteOp;
        cc_wr          = s.ccWr;
        cc_in          = s.ccIn;
        spl_wr         = s.splWr;
        spl_in         = s.splIn;
        trap_ld        = s.trapLd;
        trap_psw       = s.trapPsw;
        rti_ld         = s.rtiLd;
        rtt            = s.rttIn;
        stk_psw        = s.stkPsw;
        instr_start    = s.iStart;
        instr_done     = s.iDone;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string n, input logic [15:0] expPsw, input logic expTr);
        checks++;
        if (psw !== expPsw) begin
            errors++;
            $display("[TB] FAIL %s psw: got %06o want %06o", n, psw, expPsw);
        end
        checks++;
        if (trace_req !== expTr) begin
            errors++;
            $display("[TB] FAIL %s trace_req: got %b want %b", n, trace_req, expTr);
        end
    endtask

    // Field-level model of one clock edge; returns the expected outputs.
    task automatic modelStep(input stim_t s, output logic [15:0] ePsw, output logic eTr);
        bit io, kern, lo, hi;
        if (s.rst) begin
            mCur = 0; mPrev = 0; mPrio = 0; mT = 0; mNzvc = 0;
            mCcSup = 0; mArmed = 0; mInhibit = 0; mTr = 0;
        end else begin
            io   = s.wr && (s.addr == 13'o17776 || s.addr == 13'o17777);
            kern = (mCur == 0);
            mTr  = 0;
            if (s.trapLd) begin
                mArmed = 0; mInhibit = 0;
            end else if (s.rtiLd && s.rttIn) begin
                mArmed = 0; mInhibit = 1;
            end else begin
                if (s.iDone && mArmed) begin
                    mTr = 1; mArmed = 0;
                end
                if (s.iStart) begin
                    if (mInhibit) mInhibit = 0;
                    else if (!mArmed && mT != 0) mArmed = 1;
                end
            end
            if (s.trapLd) begin
                mPrev = mCur;
                mCur  = s.trapPsw[15:14];
                mPrio = s.trapPsw[7:5];
                mT    = s.trapPsw[4];
                mNzvc = s.trapPsw[3:0];
            end else if (s.rtiLd) begin
                if (kern) begin
                    mCur  = s.stkPsw[15:14];
                    mPrev = s.stkPsw[13:12];
                    mPrio = s.stkPsw[7:5];
                end else begin
                    mCur  = mCur | s.stkPsw[15:14];
                    mPrev = mPrev | s.stkPsw[13:12];
                end
                mT    = s.stkPsw[4];
                mNzvc = s.stkPsw[3:0];
            end else if (io) begin
                lo = !s.byteOp || s.addr == 13'o17776;
                hi = !s.byteOp || s.addr == 13'o17777;
                if (hi) begin
                    mCur  = s.din[15:14];
                    mPrev = s.din[13:12];
                end
                if (lo) begin
                    mPrio = s.din[7:5];
                    mNzvc = s.din[3:0];
                end
            end else if (s.splWr) begin
                if (kern) mPrio = s.splIn;
            end else if (s.ccWr && !mCcSup) begin
                mNzvc = s.ccIn;
            end
            if (io) mCcSup = 1;
            else if (s.iStart) mCcSup = 0;
        end
        ePsw = 16'(mCur * 16384 + mPrev * 4096 + mPrio * 32 + mT * 16 + mNzvc);
        eTr  = mTr;
    endtask

    // Directed table, then randomized run against the model.
    initial begin
        stim_t s;
        logic [15:0] ePsw;
        logic eTr, eSel;

        addVec("reset",            rstS(), 16'o000000, 1'b0);
        addVec("word wr 177777",   ioS(13'o17776, 16'o177777, 1'b0), 16'o170357, 1'b0);
        addVec("reset2",           rstS(), 16'o000000, 1'b0);
        addVec("trap 030340",      trapS(16'o030340), 16'o000340, 1'b0);
        addVec("trap 140000",      trapS(16'o140000), 16'o140000, 1'b0);
        addVec("trap prev mode",   trapS(16'o000000), 16'o030000, 1'b0);
        addVec("reset3",           rstS(), 16'o000000, 1'b0);
        s = ioS(13'o17776, 16'o000017, 1'b1); s.ccWr = 1'b1; s.ccIn = 4'b0000;
        addVec("byte wr lo + cc",  s, 16'o000017, 1'b0);
        addVec("cc suppressed",    ccS(4'b0000), 16'o000017, 1'b0);
        addVec("instr start",      instrS(1'b1, 1'b0), 16'o000017, 1'b0);
        addVec("cc after start",   ccS(4'b0101), 16'o000005, 1'b0);
        addVec("byte wr hi",       ioS(13'o17777, 16'hA0F0, 1'b1), 16'o120005, 1'b0);
        addVec("reset4",           rstS(), 16'o000000, 1'b0);
        addVec("word wr 170000",   ioS(13'o17776, 16'o170000, 1'b0), 16'o170000, 1'b0);
        addVec("user rti 000340",  rtiS(16'o000340, 1'b0), 16'o170000, 1'b0);
        addVec("user spl 7",       splS(3'd7), 16'o170000, 1'b0);
        addVec("user rti 000037",  rtiS(16'o000037, 1'b0), 16'o170037, 1'b0);
        addVec("reset5",           rstS(), 16'o000000, 1'b0);
        addVec("kernel rti T",     rtiS(16'o000020, 1'b0), 16'o000020, 1'b0);
        addVec("start armed",      instrS(1'b1, 1'b0), 16'o000020, 1'b0);
        addVec("done trace",       instrS(1'b0, 1'b1), 16'o000020, 1'b1);
        addVec("trace one cycle",  idleS(), 16'o000020, 1'b0);
        addVec("rtt",              rtiS(16'o000020, 1'b1), 16'o000020, 1'b0);
        addVec("rtt start1",       instrS(1'b1, 1'b0), 16'o000020, 1'b0);
        addVec("rtt done1",        instrS(1'b0, 1'b1), 16'o000020, 1'b0);
        addVec("rtt start2",       instrS(1'b1, 1'b0), 16'o000020, 1'b0);
        addVec("rtt done2",        instrS(1'b0, 1'b1), 16'o000020, 1'b1);
        addVec("rtt idle",         idleS(), 16'o000020, 1'b0);
        addVec("arm before trap",  instrS(1'b1, 1'b0), 16'o000020, 1'b0);
        s = trapS(16'o000020); s.iDone = 1'b1;
        addVec("trap cancels",     s, 16'o000020, 1'b0);
        addVec("after cancel",     idleS(), 16'o000020, 1'b0);
        addVec("arm again",        instrS(1'b1, 1'b0), 16'o000020, 1'b0);
        addVec("start+done",       instrS(1'b1, 1'b1), 16'o000020, 1'b1);
        addVec("done rearmed",     instrS(1'b0, 1'b1), 16'o000020, 1'b1);
        addVec("idle",             idleS(), 16'o000020, 1'b0);
        addVec("arm pre reset",    instrS(1'b1, 1'b0), 16'o000020, 1'b0);
        s = rstS(); s.iDone = 1'b1; s.trapLd = 1'b1; s.trapPsw = 16'o177777;
        s.wr = 1'b1; s.addr = 13'o17776; s.din = 16'o177777;
        addVec("reset overrides",  s, 16'o000000, 1'b0);
        addVec("done after reset", instrS(1'b0, 1'b1), 16'o000000, 1'b0);
        addVec("start T=0",        instrS(1'b1, 1'b0), 16'o000000, 1'b0);
        addVec("kernel spl 5",     splS(3'd5), 16'o000240, 1'b0);
        addVec("cc 1010",          ccS(4'b1010), 16'o000252, 1'b0);
        addVec("rti set T",        rtiS(16'o000020, 1'b0), 16'o000020, 1'b0);
        addVec("word wr keeps T",  ioS(13'o17776, 16'o000000, 1'b0), 16'o000020, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].s);
            checkOutput(vecs[i].name, vecs[i].expPsw, vecs[i].expTr);
        end

        for (int i = 0; i < 3000; i++) begin
            s = idleS();
            s.rst = (i == 0) || ($urandom_range(63) == 0);
            case ($urandom_range(3))
                0:       s.addr = 13'o17776;
                1:       s.addr = 13'o17777;
                default: s.addr = 13'($urandom);
            endcase
            s.din     = 16'($urandom);
            s.wr      = ($urandom_range(3) == 0);
            s.byteOp  = 1'($urandom);
            s.ccWr    = 1'($urandom);
            s.ccIn    = 4'($urandom);
            s.splWr   = ($urandom_range(3) == 0);
            s.splIn   = 3'($urandom);
            s.trapLd  = ($urandom_range(15) == 0);
            s.trapPsw = 16'($urandom);
            s.rtiLd   = ($urandom_range(11) == 0);
            s.rttIn   = 1'($urandom);
            s.stkPsw  = 16'($urandom);
            s.iStart  = ($urandom_range(2) == 0);
            s.iDone   = ($urandom_range(2) == 0);
            eSel = (s.addr == 13'o17776) || (s.addr == 13'o17777);
            modelStep(s, ePsw, eTr);
            applyStimulus(s);
            checkOutput("random", ePsw, eTr);
            checks++;
            if (psw_sel !== eSel) begin
                errors++;
                $display("[TB] FAIL random psw_sel addr=%05o: got %b want %b", s.addr, psw_sel, eSel);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
